// File: rtl/fetch_unit_pkg.sv
// Fetch-stage types shared with the decoder: instruction word, FIFO entry, FSM state.
package fetch_unit_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef logic [31:0] instruction_word_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    instruction_word_t   instruction;
    logic                pred_taken;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Generic synchronous FIFO: registered head, flush dominates push/pop, push at full only with a pop.
// Head is visible the cycle after the push; the caller owns credit so push at full is dropped.
module fetch_unit_sync_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [7:0],
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding imem request, static JAL/backward-branch prediction, FIFO toward decode.
// Requests issue only with a free FIFO slot; redirects flush the FIFO and drop the stale response.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               XLEN     = 64,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  output logic [31:0]     dec_instruction,
  output logic [XLEN-1:0] dec_pc,
  output logic            dec_branch_taken,
  input  logic            dec_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            drop_q, drop_d;

  logic             push;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_fifo_full;

  function automatic logic predict_taken(input instruction_word_t i);
    return (i[6:0] == OPC_JAL) || ((i[6:0] == OPC_BRANCH) && i[31]);
  endfunction

  function automatic logic [XLEN-1:0] predict_next_pc(input instruction_word_t i,
                                                      input logic [XLEN-1:0] pc);
    logic [20:0] imm_j;
    logic [12:0] imm_b;
    imm_j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    imm_b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    if (i[6:0] == OPC_JAL) begin
      return pc + {{(XLEN-21){imm_j[20]}}, imm_j};
    end
    if ((i[6:0] == OPC_BRANCH) && i[31]) begin
      return pc + {{(XLEN-13){imm_b[12]}}, imm_b};
    end
    return pc + XLEN'(4);
  endfunction

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redirect_valid && (fifo_count < CNT_W'(DEPTH))) begin
          state_d    = REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (!drop_q && !redirect_valid) begin
            push       = 1'b1;
            fetch_pc_d = predict_next_pc(imem_resp_data, fetch_pc_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // The request already on the bus keeps its address; only its response is discarded.
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      if ((state_q == REQ) || ((state_q == WAIT) && !imem_resp_valid)) begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
    end
  end

  assign push_entry = '{pc:          XLEN_MAX'(fetch_pc_q),
                        instruction: imem_resp_data,
                        pred_taken:  predict_taken(imem_resp_data)};

  fetch_unit_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (dec_ready),
    .flush     (redirect_valid),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign unused_fifo_full = fifo_full;

  assign imem_req_valid   = (state_q == REQ);
  assign imem_req_addr    = req_addr_q;
  assign dec_valid        = !fifo_empty;
  assign dec_instruction  = head_entry.instruction;
  assign dec_pc           = head_entry.pc[XLEN-1:0];
  assign dec_branch_taken = head_entry.pred_taken;

endmodule
